// File: rtl/asteroid_pkg.sv
// Shared types and constants for the survival-time display path.
package asteroid_pkg;

  // Tracker states: menu, live play, one-cycle compare, post-game display.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CAPTURE = 2'd2,
    SHOW    = 2'd3
  } state_t;

  // One BCD display digit.
  typedef logic [3:0] bcd_t;

  // Timing is counted in pulses of the 30 Hz tick divider.
  localparam int TICK_HZ         = 30;
  localparam int SHOW_TICKS_DEF  = 90;  // 3 s per display phase
  localparam int BLINK_TICKS_DEF = 15;  // 0.5 s per blink half-period

  // Digit value the hex decoder renders as "F"; used as the flash pattern.
  localparam bcd_t BCD_FLASH = 4'hF;

endpackage

// File: rtl/bcd4_greater.sv
// Combinational 4-digit BCD magnitude compare: gt = (a > b).
// Most significant digit decides first; digits above 9 compare numerically.
module bcd4_greater
  import asteroid_pkg::*;
(
  input  bcd_t a0,
  input  bcd_t a1,
  input  bcd_t a2,
  input  bcd_t a3,
  input  bcd_t b0,
  input  bcd_t b1,
  input  bcd_t b2,
  input  bcd_t b3,
  output logic gt
);

  // Walk from digit 3 down; the first differing digit sets the result.
  always_comb begin
    gt = 1'b0;
    if (a3 != b3)      gt = (a3 > b3);
    else if (a2 != b2) gt = (a2 > b2);
    else if (a1 != b1) gt = (a1 > b1);
    else               gt = (a0 > b0);
  end

endmodule

// File: rtl/best_time_tracker.sv
// Best survival time tracker and display mux.
// Captures the final time at game over, keeps the longest time since reset,
// and drives four registered BCD digits: best in menu, live in play,
// final/best alternating after game over.
// Build option NEW_RECORD_BLINK_EN: flash all digits to "F" during the blink
// phase of a new record; when undefined the blink output is tied low.
//
// Handshake note: tick and game_over are single-cycle strobes with no ready;
// each asserted cycle is one event. A tick in the CAPTURE cycle is dropped.
module best_time_tracker
  import asteroid_pkg::*;
#(
  parameter int SHOW_TICKS  = SHOW_TICKS_DEF,
  parameter int BLINK_TICKS = BLINK_TICKS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       game_state,
  input  logic       game_over,
  input  logic [3:0] cur0,
  input  logic [3:0] cur1,
  input  logic [3:0] cur2,
  input  logic [3:0] cur3,
  output logic [3:0] disp0,
  output logic [3:0] disp1,
  output logic [3:0] disp2,
  output logic [3:0] disp3,
  output logic       disp_is_best,
  output logic       new_record,
  output logic       blink
);

  localparam int PW = (SHOW_TICKS > 1) ? $clog2(SHOW_TICKS) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(SHOW_TICKS - 1);

  state_t              state;
  state_t              state_n;
  logic [3:0][3:0]     cur_v;
  logic [3:0][3:0]     best_q;
  logic [3:0][3:0]     final_q;
  logic [3:0][3:0]     disp_q;
  logic [3:0][3:0]     disp_n;
  logic                is_best_n;
  logic                final_gt;
  logic [PW-1:0]       phase_cnt;
  logic                phase_wrap;

  assign cur_v = {cur3, cur2, cur1, cur0};
  assign disp0 = disp_q[0];
  assign disp1 = disp_q[1];
  assign disp2 = disp_q[2];
  assign disp3 = disp_q[3];

  bcd4_greater u_cmp (
    .a0 (final_q[0]),
    .a1 (final_q[1]),
    .a2 (final_q[2]),
    .a3 (final_q[3]),
    .b0 (best_q[0]),
    .b1 (best_q[1]),
    .b2 (best_q[2]),
    .b3 (best_q[3]),
    .gt (final_gt)
  );

  assign phase_wrap = (state == SHOW) && tick && (phase_cnt == PHASE_LAST);

`ifdef NEW_RECORD_BLINK_EN
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  logic          blink_q;
  logic          blink_n;
  logic [BW-1:0] blink_cnt;
  logic          blink_wrap;

  assign blink      = blink_q;
  assign blink_wrap = (state == SHOW) && tick && (blink_cnt == BLINK_LAST);

  // Blink half-period counter and phase flag; restarted at every capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_q   <= 1'b0;
    end else begin
      blink_q <= blink_n;
      if (state == CAPTURE)
        blink_cnt <= '0;
      else if ((state == SHOW) && tick)
        blink_cnt <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
    end
  end
`else
  assign blink = 1'b0;
`endif

  // Next-state logic; game_state=1 returns to menu from anywhere.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (!game_state) state_n = RUN;
      RUN: begin
        if (game_state)     state_n = IDLE;
        else if (game_over) state_n = CAPTURE;
      end
      CAPTURE: state_n = game_state ? IDLE : SHOW;
      SHOW:    if (game_state) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next display value and best/final selector, registered below.
  always_comb begin
    disp_n    = best_q;
    is_best_n = 1'b1;
`ifdef NEW_RECORD_BLINK_EN
    blink_n   = 1'b0;
`endif
    case (state)
      IDLE: begin
        disp_n    = best_q;
        is_best_n = 1'b1;
      end
      RUN: begin
        disp_n    = cur_v;
        is_best_n = 1'b0;
      end
      CAPTURE: begin
        disp_n    = final_q;
        is_best_n = 1'b0;
      end
      SHOW: begin
        is_best_n = disp_is_best ^ phase_wrap;
        disp_n    = is_best_n ? best_q : final_q;
`ifdef NEW_RECORD_BLINK_EN
        blink_n = new_record & (blink_q ^ blink_wrap);
        if (blink_n) disp_n = {4{BCD_FLASH}};
`endif
      end
      default: begin
        disp_n    = best_q;
        is_best_n = 1'b1;
      end
    endcase
  end

  // State, captured times, record flag, phase counter and display registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      best_q       <= '0;
      final_q      <= '0;
      disp_q       <= '0;
      disp_is_best <= 1'b1;
      new_record   <= 1'b0;
      phase_cnt    <= '0;
    end else begin
      state        <= state_n;
      disp_q       <= disp_n;
      disp_is_best <= is_best_n;
      if ((state == IDLE) && !game_state)
        new_record <= 1'b0;
      if ((state == RUN) && !game_state && game_over)
        final_q <= cur_v;
      if ((state == CAPTURE) && !game_state) begin
        if (final_gt) begin
          best_q     <= final_q;
          new_record <= 1'b1;
        end else begin
          new_record <= 1'b0;
        end
      end
      if (state == CAPTURE)
        phase_cnt <= '0;
      else if ((state == SHOW) && tick)
        phase_cnt <= phase_wrap ? '0 : phase_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_best_time_tracker.sv
// Self-checking bench for best_time_tracker against a behavioural model.
module tb_best_time_tracker;

  localparam int SHOW_T  = 90;
  localparam int BLINK_T = 15;
`ifdef NEW_RECORD_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_CAP  = 2;
  localparam int M_SHOW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset, tick, game_state, game_over;
  logic [3:0] cur0, cur1, cur2, cur3;
  logic [3:0] disp0, disp1, disp2, disp3;
  logic disp_is_best, new_record, blink;

  always #5 clk = ~clk;

  best_time_tracker dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .game_state   (game_state),
    .game_over    (game_over),
    .cur0         (cur0),
    .cur1         (cur1),
    .cur2         (cur2),
    .cur3         (cur3),
    .disp0        (disp0),
    .disp1        (disp1),
    .disp2        (disp2),
    .disp3        (disp3),
    .disp_is_best (disp_is_best),
    .new_record   (new_record),
    .blink        (blink)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  // Reference state: times held as 16-bit digit concatenations, so the
  // digit-by-digit magnitude compare is a plain numeric compare.
  int          m_mode  = M_IDLE;
  logic [15:0] m_best  = '0;
  logic [15:0] m_final = '0;
  logic        m_nrec  = 1'b0;
  int          m_ticks = 0;   // ticks seen since entering SHOW

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic rst, input logic gs, input logic go,
                       input logic tk, input logic [15:0] c);
    logic [15:0] e_disp;
    logic        e_isb;
    logic        e_blink;
    @(negedge clk);
    reset      = rst;
    game_state = gs;
    game_over  = go;
    tick       = tk;
    {cur3, cur2, cur1, cur0} = c;
    @(posedge clk);
    #1;
    e_blink = 1'b0;
    if (rst) begin
      m_mode = M_IDLE; m_best = '0; m_final = '0; m_nrec = 1'b0; m_ticks = 0;
      e_disp = '0; e_isb = 1'b1;
    end else begin
      case (m_mode)
        M_IDLE: begin
          e_disp = m_best; e_isb = 1'b1;
          if (!gs) begin m_mode = M_RUN; m_nrec = 1'b0; end
        end
        M_RUN: begin
          e_disp = c; e_isb = 1'b0;
          if (gs) m_mode = M_IDLE;
          else if (go) begin m_final = c; m_mode = M_CAP; end
        end
        M_CAP: begin
          e_disp = m_final; e_isb = 1'b0;
          if (gs) m_mode = M_IDLE;
          else begin
            m_nrec = (m_final > m_best);
            if (m_nrec) m_best = m_final;
            m_ticks = 0;
            m_mode  = M_SHOW;
          end
        end
        default: begin
          if (tk) m_ticks++;
          e_isb   = ((m_ticks / SHOW_T) % 2) == 1;
          e_blink = BLINK_EN && m_nrec && (((m_ticks / BLINK_T) % 2) == 1);
          e_disp  = e_blink ? 16'hFFFF : (e_isb ? m_best : m_final);
          if (gs) m_mode = M_IDLE;
        end
      endcase
    end
    check("disp",       {disp3, disp2, disp1, disp0}, e_disp);
    check("disp_is_best", 16'(disp_is_best), 16'(e_isb));
    check("new_record",   16'(new_record),   16'(m_nrec));
    check("blink",        16'(blink),        16'(e_blink));
  endtask

  function automatic logic rnd_tick();
    return ($urandom_range(0, 3) != 0);
  endfunction

  function automatic logic [15:0] rnd_time();
    logic [15:0] v;
    for (int i = 0; i < 4; i++)
      v[i*4 +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                : 4'($urandom_range(0, 9));
    return v;
  endfunction

  task automatic cyc(input logic gs, input logic go, input logic [15:0] c);
    cycle(1'b0, gs, go, rnd_tick(), c);
  endtask

  // Menu, play, game over on final time c, then show_len cycles of SHOW.
  // Stray game_over pulses in menu and SHOW must be ignored.
  task automatic game(input logic [15:0] c, input int run_len, input int show_len);
    for (int i = 0; i < 3; i++) cyc(1'b1, ($urandom_range(0, 2) == 0), rnd_time());
    for (int i = 0; i < run_len; i++) cyc(1'b0, 1'b0, rnd_time());
    cyc(1'b0, 1'b1, c);
    for (int i = 0; i < show_len; i++)
      cyc(1'b0, ($urandom_range(0, 20) == 0), rnd_time());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; game_state = 1'b1; game_over = 1'b0; tick = 1'b0;
    {cur3, cur2, cur1, cur0} = '0;

    // Reset, then idle in menu
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 16'h0000);

    // First game: new record, then worse game, then tie
    game(16'h0123, 5, 220);
    game(16'h0099, 4, 420);
    game(16'h0123, 3, 150);

    // Abort: game_state and game_over together during play
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, rnd_time());
    cyc(1'b1, 1'b1, 16'h9999);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'h0000);

    // New record at 0500, watch blink, then reset in the middle of SHOW
    game(16'h0500, 2, 160);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'h0000);

    // Random games
    for (int g = 0; g < 20; g++)
      game(rnd_time(), $urandom_range(1, 12), $urandom_range(0, 300));
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
